// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arp_pkg
//  Purpose  : Shared definitions for the ARP transmit path: frame-section
//             state encodings, section lengths, protocol constants and small
//             byte-selection helpers.
//  Revision : 1.0  initial release
// ============================================================================
package arp_pkg;

  // Frame sections in transmit order. Four bits leave spare encodings, and
  // the FSM sends any of those straight back to IDLE.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_SFD      = 4'd2,
    S_ETH_HDR  = 4'd3,
    S_ARP_DATA = 4'd4,
    S_PADDING  = 4'd5,
    S_FCS      = 4'd6,
    S_IFG      = 4'd7
  } arp_state_e;

  localparam int unsigned LEN_PREAMBLE = 7;
  localparam int unsigned LEN_SFD      = 1;
  localparam int unsigned LEN_ETH_HDR  = 14;
  localparam int unsigned LEN_ARP_DATA = 28;
  localparam int unsigned LEN_PADDING  = 18;
  localparam int unsigned LEN_FCS      = 4;
  localparam int unsigned LEN_IFG      = 12;

  localparam int unsigned CNT_W = 5;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Bit-reversed form of 0x04C11DB7 for the LSB-first (reflected) CRC.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // Index of the final byte of each section; the byte counter advances the
  // FSM when it reaches this value.
  function automatic logic [CNT_W-1:0] stage_last(input arp_state_e s);
    case (s)
      S_PREAMBLE: return CNT_W'(LEN_PREAMBLE - 1);
      S_SFD:      return CNT_W'(LEN_SFD - 1);
      S_ETH_HDR:  return CNT_W'(LEN_ETH_HDR - 1);
      S_ARP_DATA: return CNT_W'(LEN_ARP_DATA - 1);
      S_PADDING:  return CNT_W'(LEN_PADDING - 1);
      S_FCS:      return CNT_W'(LEN_FCS - 1);
      S_IFG:      return CNT_W'(LEN_IFG - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic arp_state_e stage_next(input arp_state_e s);
    case (s)
      S_PREAMBLE: return S_SFD;
      S_SFD:      return S_ETH_HDR;
      S_ETH_HDR:  return S_ARP_DATA;
      S_ARP_DATA: return S_PADDING;
      S_PADDING:  return S_FCS;
      S_FCS:      return S_IFG;
      default:    return S_IDLE;
    endcase
  endfunction

  // Byte idx (0 = most significant) of a 48-bit field.
  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [CNT_W-1:0] idx);
    logic [47:0] s;
    s = v << {idx, 3'b000};
    return s[47:40];
  endfunction

  // Byte idx (0 = most significant) of a 32-bit field.
  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [CNT_W-1:0] idx);
    logic [31:0] s;
    s = v << {idx, 3'b000};
    return s[31:24];
  endfunction

endpackage
`default_nettype wire

// File: rtl/arp_tx_crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_d8
//  Purpose  : Combinational CRC-32 (poly 0x04C11DB7, reflected) next-state
//             for one data byte, data consumed LSB first as on Ethernet.
//  Ports    : crc_in  [31:0] current CRC register
//             data    [7:0]  byte being added
//             crc_out [31:0] CRC after absorbing data
//  Revision : 1.0  initial release
// ============================================================================
module crc32_d8
  import arp_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  always_comb begin
    w_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_c[0] ^ data[i]) begin
        w_c = (w_c >> 1) ^ CRC_POLY_REFL;
      end else begin
        w_c = w_c >> 1;
      end
    end
    crc_out = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/arp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : arp_tx
//  Purpose  : Builds a complete Ethernet II ARP request/reply frame (preamble,
//             SFD, MAC header, ARP payload, padding, FCS) onto GMII TX, then
//             holds off for the inter-frame gap.
//  Ports    : clk          GMII TX clock
//             rst          asynchronous active-high reset
//             arp_tx_en    start pulse, honoured only in IDLE
//             arp_tx_op    1 = request, 0 = reply
//             des_mac      peer MAC (replies only)
//             des_ip       peer / target IP
//             gmii_tx_en   frame byte valid
//             gmii_txd     frame byte
//             arp_tx_busy  accept .. end of IFG
//             arp_tx_done  one-cycle pulse after the last FCS byte
//  Revision : 1.0  initial release
// ============================================================================
module arp_tx
  import arp_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC = 48'h11_22_33_44_55_66,
  parameter logic [31:0] FPGA_IP  = 32'hc0_a8_00_08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_op,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        arp_tx_busy,
  output logic        arp_tx_done
);

  // r_state / r_cnt name the byte currently on the GMII outputs.
  arp_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_req;
  logic [47:0]      r_des_mac;
  logic [31:0]      r_des_ip;
  logic [31:0]      r_crc;
  logic             r_gmii_tx_en;
  logic [7:0]       r_gmii_txd;
  logic             r_busy;
  logic             r_done;

  arp_state_e       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [CNT_W-1:0] w_idx;
  logic [7:0]       w_byte;
  logic             w_tx_en;
  logic             w_crc_upd;
  logic [31:0]      w_crc_next;
  logic [31:0]      w_fcs_sh;
  logic [15:0]      w_op;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && arp_tx_en;
  assign w_op     = r_op_req ? ARP_OP_REQ : ARP_OP_REPLY;

  // Position of the byte that will be driven after the coming edge.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 5'd1;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (arp_tx_en) begin
          w_nxt_state = S_PREAMBLE;
        end
      end
      S_PREAMBLE, S_SFD, S_ETH_HDR, S_ARP_DATA, S_PADDING, S_FCS, S_IFG: begin
        if (r_cnt == stage_last(r_state)) begin
          w_nxt_state = stage_next(r_state);
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // FCS bytes go out complemented, least significant byte first. The CRC
  // register is frozen during FCS, so it already covers all 60 bytes.
  assign w_fcs_sh = (~r_crc) >> {w_nxt_cnt[1:0], 3'b000};

  // Byte selection for the next position.
  always_comb begin
    w_byte    = 8'h00;
    w_tx_en   = 1'b1;
    w_crc_upd = 1'b0;
    w_idx     = '0;
    case (w_nxt_state)
      S_PREAMBLE: w_byte = 8'h55;
      S_SFD:      w_byte = 8'hD5;
      S_ETH_HDR: begin
        w_crc_upd = 1'b1;
        if (w_nxt_cnt < 5'd6) begin
          w_byte = r_op_req ? 8'hFF : byte_of48(r_des_mac, w_nxt_cnt);
        end else if (w_nxt_cnt < 5'd12) begin
          w_idx  = w_nxt_cnt - 5'd6;
          w_byte = byte_of48(FPGA_MAC, w_idx);
        end else if (w_nxt_cnt == 5'd12) begin
          w_byte = ETH_TYPE_ARP[15:8];
        end else begin
          w_byte = ETH_TYPE_ARP[7:0];
        end
      end
      S_ARP_DATA: begin
        w_crc_upd = 1'b1;
        case (w_nxt_cnt)
          5'd0: w_byte = ARP_HTYPE[15:8];
          5'd1: w_byte = ARP_HTYPE[7:0];
          5'd2: w_byte = ARP_PTYPE[15:8];
          5'd3: w_byte = ARP_PTYPE[7:0];
          5'd4: w_byte = ARP_HLEN;
          5'd5: w_byte = ARP_PLEN;
          5'd6: w_byte = w_op[15:8];
          5'd7: w_byte = w_op[7:0];
          default: begin
            if (w_nxt_cnt < 5'd14) begin
              w_idx  = w_nxt_cnt - 5'd8;
              w_byte = byte_of48(FPGA_MAC, w_idx);
            end else if (w_nxt_cnt < 5'd18) begin
              w_idx  = w_nxt_cnt - 5'd14;
              w_byte = byte_of32(FPGA_IP, w_idx);
            end else if (w_nxt_cnt < 5'd24) begin
              w_idx  = w_nxt_cnt - 5'd18;
              w_byte = r_op_req ? 8'h00 : byte_of48(r_des_mac, w_idx);
            end else begin
              w_idx  = w_nxt_cnt - 5'd24;
              w_byte = byte_of32(r_des_ip, w_idx);
            end
          end
        endcase
      end
      S_PADDING: begin
        w_crc_upd = 1'b1;
        w_byte    = 8'h00;
      end
      S_FCS:   w_byte = w_fcs_sh[7:0];
      default: w_tx_en = 1'b0;
    endcase
  end

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (w_byte),
    .crc_out (w_crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op_req     <= 1'b0;
      r_des_mac    <= '0;
      r_des_ip     <= '0;
      r_crc        <= CRC_INIT;
      r_gmii_tx_en <= 1'b0;
      r_gmii_txd   <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_gmii_tx_en <= w_tx_en;
      r_gmii_txd   <= w_byte;
      r_done       <= (r_state == S_FCS) && (w_nxt_state == S_IFG);

      if (w_accept) begin
        r_op_req  <= arp_tx_op;
        r_des_mac <= des_mac;
        r_des_ip  <= des_ip;
        r_busy    <= 1'b1;
      end else if (w_nxt_state == S_IDLE) begin
        // End of IFG, or recovery from an illegal encoding.
        r_busy <= 1'b0;
      end

      if (w_nxt_state == S_PREAMBLE) begin
        r_crc <= CRC_INIT;
      end else if (w_crc_upd) begin
        r_crc <= w_crc_next;
      end
    end
  end

  assign gmii_tx_en  = r_gmii_tx_en;
  assign gmii_txd    = r_gmii_txd;
  assign arp_tx_busy = r_busy;
  assign arp_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_arp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arp_tx
//  Purpose  : Self-checking bench for arp_tx. Every accepted frame is built
//             byte by byte from the ARP/Ethernet field rules and queued; a
//             monitor pops and compares each GMII byte and checks framing,
//             done pulse and inter-frame spacing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arp_tx;

  localparam logic [47:0] C_FPGA_MAC = 48'h11_22_33_44_55_66;
  localparam logic [31:0] C_FPGA_IP  = 32'hc0_a8_00_08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_op = 1'b0;
  logic [47:0] des_mac = '0;
  logic [31:0] des_ip = '0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        arp_tx_busy;
  logic        arp_tx_done;

  int n_checks = 0;
  int n_errors = 0;
  int frames_full = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];

  always #4 clk = ~clk;

  arp_tx #(.FPGA_MAC(C_FPGA_MAC), .FPGA_IP(C_FPGA_IP)) dut (
    .clk         (clk),
    .rst         (rst),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_op   (arp_tx_op),
    .des_mac     (des_mac),
    .des_ip      (des_ip),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .arp_tx_busy (arp_tx_busy),
    .arp_tx_done (arp_tx_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction

  // Ethernet FCS written as the MSB-first polynomial division on
  // bit-reversed bytes, reflected back at the end.
  function automatic logic [31:0] fcs_model(input logic [7:0] f[$], input int first, input int last);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = first; i <= last; i++) begin
      c = c ^ {rev8(f[i]), 24'h0};
      for (int b = 0; b < 8; b++) begin
        if (c[31]) c = (c << 1) ^ 32'h04C1_1DB7;
        else       c = c << 1;
      end
    end
    return ~rev32(c);
  endfunction

  function automatic void push48(inout logic [7:0] f[$], input logic [47:0] v);
    logic [47:0] t;
    for (int i = 0; i < 6; i++) begin
      t = v >> (8 * (5 - i));
      f.push_back(t[7:0]);
    end
  endfunction

  function automatic void push32(inout logic [7:0] f[$], input logic [31:0] v);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = v >> (8 * (3 - i));
      f.push_back(t[7:0]);
    end
  endfunction

  function automatic void push_frame(input bit op_req, input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0] f[$];
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    push48(f, op_req ? 48'hFFFF_FFFF_FFFF : mac);
    push48(f, C_FPGA_MAC);
    f.push_back(8'h08); f.push_back(8'h06);
    f.push_back(8'h00); f.push_back(8'h01);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h06); f.push_back(8'h04);
    f.push_back(8'h00); f.push_back(op_req ? 8'h01 : 8'h02);
    push48(f, C_FPGA_MAC);
    push32(f, C_FPGA_IP);
    push48(f, op_req ? 48'h0 : mac);
    push32(f, ip);
    for (int i = 0; i < 18; i++) f.push_back(8'h00);
    fcs = fcs_model(f, 8, 67);
    f.push_back(fcs[7:0]);   f.push_back(fcs[15:8]);
    f.push_back(fcs[23:16]); f.push_back(fcs[31:24]);
    foreach (f[i]) exp_q.push_back(f[i]);
  endfunction

  // Issue one frame; on return (unless aborted) the bench sits #1 after the
  // edge where busy fell. abort_at>0 asserts rst that many edges after accept.
  task automatic send_frame(input bit op_req, input logic [47:0] mac, input logic [31:0] ip,
                            input bit hold, input int abort_at);
    int k;
    @(negedge clk);
    arp_tx_op = op_req; des_mac = mac; des_ip = ip; arp_tx_en = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", {63'h0, arp_tx_busy}, 64'd1);
    chk("first_byte", {55'h0, gmii_tx_en, gmii_txd}, {55'h0, 1'b1, 8'h55});
    push_frame(op_req, mac, ip);
    if (!hold) arp_tx_en = 1'b0;
    k = 0;
    while (arp_tx_busy && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == 5) begin
        des_mac   = {$urandom, $urandom_range(65535, 0)};
        des_ip    = $urandom;
        arp_tx_op = ~op_req;
      end
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_txen", {63'h0, gmii_tx_en}, 64'd0);
        chk("abort_txd", {56'h0, gmii_txd}, 64'd0);
        chk("abort_busy", {63'h0, arp_tx_busy}, 64'd0);
        exp_q.delete();
        arp_tx_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    if (k >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required fall at 84", arp_tx_busy, k);
    end else begin
      chk("busy_fall_cycle", 64'(k), 64'd84);
    end
    frames_full++;
  endtask

  // Monitor: compares every GMII byte against the queue and checks framing.
  initial begin : monitor
    int  byte_cnt;
    int  idle_cnt;
    bit  prev_en;
    bit  have_prev;
    logic [7:0] e;
    byte_cnt = 0; idle_cnt = 0; prev_en = 0; have_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        byte_cnt = 0; idle_cnt = 0; prev_en = 0; have_prev = 0;
      end else if (gmii_tx_en) begin
        if (!prev_en && have_prev) chk("ifg_min", 64'(idle_cnt >= 12), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_byte: got %0h with nothing queued", gmii_txd);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (gmii_txd !== e) begin
            n_errors++;
            $display("FAIL byte[%0d]: got %0h expected %0h", byte_cnt, gmii_txd, e);
          end
        end
        if (arp_tx_done !== 1'b0) chk("done_in_frame", {63'h0, arp_tx_done}, 64'd0);
        byte_cnt++;
        prev_en = 1;
      end else begin
        if (prev_en) begin
          chk("frame_len", 64'(byte_cnt), 64'd72);
          chk("done_pulse", {63'h0, arp_tx_done}, 64'd1);
          frames_seen++;
          have_prev = 1;
          byte_cnt = 0;
          idle_cnt = 0;
        end else begin
          if (arp_tx_done !== 1'b0) chk("spurious_done", {63'h0, arp_tx_done}, 64'd0);
        end
        idle_cnt++;
        prev_en = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    chk("rst_txen", {63'h0, gmii_tx_en}, 64'd0);
    chk("rst_txd", {56'h0, gmii_txd}, 64'd0);
    chk("rst_busy", {63'h0, arp_tx_busy}, 64'd0);
    chk("rst_done", {63'h0, arp_tx_done}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reply and request with the reference values (inputs altered at N+5).
    send_frame(1'b0, 48'h1c_83_41_c5_ca_a6, 32'hc0_a8_00_02, 1'b0, 0);
    repeat (4) @(negedge clk);
    send_frame(1'b1, 48'h1c_83_41_c5_ca_a6, 32'hc0_a8_00_02, 1'b0, 0);
    repeat (2) @(negedge clk);

    // Enable held through frame and IFG, dropped as soon as busy falls:
    // exactly one frame.
    send_frame(1'b0, 48'hde_ad_be_ef_00_01, 32'h0a_00_00_01, 1'b1, 0);
    arp_tx_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_requeue_busy", {63'h0, arp_tx_busy}, 64'd0);
    chk("no_requeue_q", 64'(exp_q.size()), 64'd0);

    // Enable held across two frames: second accept at the first IDLE edge.
    send_frame(1'b1, 48'h00_11_22_33_44_55, 32'h0a_00_00_02, 1'b1, 0);
    send_frame(1'b0, 48'h66_77_88_99_aa_bb, 32'h0a_00_00_03, 1'b0, 0);
    repeat (3) @(negedge clk);

    // Reset at byte 30, then a clean frame.
    send_frame(1'b0, 48'h02_02_02_02_02_02, 32'hc0_a8_00_63, 1'b0, 29);
    repeat (5) @(negedge clk);
    send_frame(1'b0, 48'h1c_83_41_c5_ca_a6, 32'hc0_a8_00_02, 1'b0, 0);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(5, 0)) @(negedge clk);
      send_frame(1'($urandom_range(1, 0)), {$urandom, 16'($urandom)}, $urandom, 1'b0, 0);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_count", 64'(frames_seen), 64'(frames_full));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
